// File: rtl/frame_buf_pkg.sv
// Shared types and helpers for the ping-pong frame buffer.
// Contents:
//   bank_t / BANK0 / BANK1 : one-bit bank selector and its two values
//   rd_state_t             : read-side state (idle / holding a frame)
//   OVR_CNT_W              : width of the optional overrun counter
//   addr_w(n)              : address width needed for an n-sample frame
package frame_buf_pkg;

  typedef logic bank_t;
  localparam bank_t BANK0 = 1'b0;
  localparam bank_t BANK1 = 1'b1;

  typedef enum logic {
    RD_IDLE,
    RD_BUSY
  } rd_state_t;

  localparam int OVR_CNT_W = 16;

  function automatic int addr_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/frame_pingpong_buf_if.sv
// Stream / playback bundle between the sample source, the frame buffer and
// the downstream address sequencer.
// Signals:
//   in_valid, in_data : write stream (source -> buffer)
//   frame_ready       : a complete frame is held for reading
//   rd_en             : read next sample of held frame (sequencer -> buffer)
//   rd_data, rd_valid, rd_last : registered playback
//   overrun           : one-cycle pulse when a frame is dropped
//   wr_bank           : bank currently being written
//   overrun_cnt       : saturating overrun count, only with FRAME_BUF_OVR_CNT_EN
// Modports: master = source/sequencer side, slave = buffer side.
interface frame_pingpong_buf_if #(
  parameter int DW = 12
);
  import frame_buf_pkg::*;

  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          frame_ready;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_last;
  logic          overrun;
  bank_t         wr_bank;
`ifdef FRAME_BUF_OVR_CNT_EN
  logic [OVR_CNT_W-1:0] overrun_cnt;
`endif

  modport master (
    output in_valid, in_data, rd_en,
    input  frame_ready, rd_data, rd_valid, rd_last, overrun, wr_bank
`ifdef FRAME_BUF_OVR_CNT_EN
    , input overrun_cnt
`endif
  );

  modport slave (
    input  in_valid, in_data, rd_en,
    output frame_ready, rd_data, rd_valid, rd_last, overrun, wr_bank
`ifdef FRAME_BUF_OVR_CNT_EN
    , output overrun_cnt
`endif
  );

endinterface

// File: rtl/frame_pingpong_buf_sdp_ram.sv
// sdp_ram: simple dual-port RAM, one write port and one registered read port.
// Ports:
//   clk          : clock
//   rst          : synchronous active-high reset, clears only the read register
//   we/waddr/wdata : write port
//   re/raddr     : read request; rdata updates one cycle later, holds otherwise
//   rdata        : registered read data
// Storage contents are never cleared.
module sdp_ram #(
  parameter int DW = 12,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [1<<AW];

  // Write port; no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; output holds its value when no read is requested.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/frame_pingpong_buf.sv
// frame_pingpong_buf: two-bank frame buffer between the ADC sample stream and
// the spectrum analyzer's address sequencer. The writer fills one bank while
// the reader plays back the other; a frame completing while the reader still
// holds one is dropped and flagged with an overrun pulse.
// Ports:
//   clk : clock, all logic on rising edge
//   RE  : synchronous active-high reset, dominates every other input
//   bus : frame_pingpong_buf_if.slave (stream in, playback out, status)
// Parameters: DW sample width, N frame length (power of 2, >= 2).
// Optional: define FRAME_BUF_OVR_CNT_EN to add the 16-bit saturating
// overrun_cnt output on the interface.
module frame_pingpong_buf
  import frame_buf_pkg::*;
#(
  parameter int DW = 12,
  parameter int N  = 64
) (
  input  logic                  clk,
  input  logic                  RE,
  frame_pingpong_buf_if.slave   bus
);

  localparam int AW = addr_w(N);
  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

  rd_state_t     rd_state;
  bank_t         wr_bank;
  bank_t         rd_bank;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic          rd_last;
  logic          overrun;

  logic frame_ready;
  logic rd_fire;
  logic wr_fire;
  logic frame_done;
  logic read_done;
  logic reader_free;

  assign frame_ready = (rd_state == RD_BUSY);
  assign rd_fire     = frame_ready && bus.rd_en && !RE;
  assign wr_fire     = bus.in_valid && !RE;
  assign frame_done  = bus.in_valid && (wr_addr == LAST_ADDR);
  assign read_done   = rd_fire && (rd_addr == LAST_ADDR);
  // The reader can accept a new frame if idle, or if it finishes this cycle.
  assign reader_free = !frame_ready || read_done;

  // Control: address counters, bank swap on frame completion, overrun flag.
  // Counters wrap mod N through natural AW-bit overflow, so after a final
  // read or write they are already back at 0 for the next frame.
  always_ff @(posedge clk) begin
    if (RE) begin
      rd_state <= RD_IDLE;
      wr_bank  <= BANK0;
      rd_bank  <= BANK0;
      wr_addr  <= '0;
      rd_addr  <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun  <= 1'b0;
      rd_valid <= rd_fire;
      rd_last  <= read_done;
      if (rd_fire) begin
        rd_addr <= rd_addr + AW'(1);
      end
      if (bus.in_valid) begin
        wr_addr <= wr_addr + AW'(1);
      end
      if (frame_done && reader_free) begin
        rd_state <= RD_BUSY;
        rd_bank  <= wr_bank;
        wr_bank  <= (wr_bank == BANK0) ? BANK1 : BANK0;
      end else if (frame_done) begin
        overrun <= 1'b1;
      end else if (read_done) begin
        rd_state <= RD_IDLE;
      end
    end
  end

  sdp_ram #(
    .DW (DW),
    .AW (AW + 1)
  ) u_ram (
    .clk   (clk),
    .rst   (RE),
    .we    (wr_fire),
    .waddr ({wr_bank, wr_addr}),
    .wdata (bus.in_data),
    .re    (rd_fire),
    .raddr ({rd_bank, rd_addr}),
    .rdata (bus.rd_data)
  );

`ifdef FRAME_BUF_OVR_CNT_EN
  logic [OVR_CNT_W-1:0] overrun_cnt;

  // Saturating count of dropped frames, advanced by the registered pulse.
  always_ff @(posedge clk) begin
    if (RE) begin
      overrun_cnt <= '0;
    end else if (overrun && (overrun_cnt != '1)) begin
      overrun_cnt <= overrun_cnt + OVR_CNT_W'(1);
    end
  end

  assign bus.overrun_cnt = overrun_cnt;
`endif

  assign bus.frame_ready = frame_ready;
  assign bus.rd_valid    = rd_valid;
  assign bus.rd_last     = rd_last;
  assign bus.overrun     = overrun;
  assign bus.wr_bank     = wr_bank;

endmodule

// File: tb/tb_frame_pingpong_buf.sv
// Self-checking bench for frame_pingpong_buf (DW=12, N=64).
// A short vector table covers reset and idle behaviour; hand-written
// sequences cover full frames, overrun, aligned swap and mid-frame reset.
// Define FRAME_BUF_OVR_CNT_EN to also check overrun_cnt.
module tb_frame_pingpong_buf;

  localparam int DW = 12;
  localparam int N  = 64;

  logic clk = 1'b0;
  logic RE  = 1'b1;

  int total = 0;
  int bad   = 0;

  frame_pingpong_buf_if #(.DW(DW)) bus ();

  frame_pingpong_buf #(
    .DW (DW),
    .N  (N)
  ) dut (
    .clk (clk),
    .RE  (RE),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          re;
    logic          iv;
    logic [DW-1:0] d;
    logic          ren;
    logic          exp_fr;
    logic          exp_rv;
    logic          exp_ovr;
    logic          exp_wb;
  } vec_t;

  vec_t vecs [7];

  // Drive one cycle of inputs, then settle 1 time unit past the edge.
  task automatic applyStimulus(input logic re, input logic iv, input int d, input logic ren);
    RE           = re;
    bus.in_valid = iv;
    bus.in_data  = DW'(d);
    bus.rd_en    = ren;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic writeFrame(input int base);
    for (int i = 0; i < N; i++) begin
      applyStimulus(1'b0, 1'b1, base + i, 1'b0);
    end
  endtask

  task automatic readFrame(input string tag, input int base);
    for (int k = 0; k < N; k++) begin
      applyStimulus(1'b0, 1'b0, 0, 1'b1);
      checkOutput({tag, "_rv"}, int'(bus.rd_valid), 1);
      checkOutput({tag, "_data"}, int'(bus.rd_data), base + k);
      checkOutput({tag, "_last"}, int'(bus.rd_last), (k == N - 1) ? 1 : 0);
      checkOutput({tag, "_fr"}, int'(bus.frame_ready), (k == N - 1) ? 0 : 1);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.rd_en    = 1'b0;

    //                re    iv    d      ren   fr    rv    ovr   wb
    vecs[0] = '{1'b0, 1'b0, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 12'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 12'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 12'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset
    applyStimulus(1'b1, 1'b0, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 0, 1'b0);
    checkOutput("rst_fr", int'(bus.frame_ready), 0);
    checkOutput("rst_rv", int'(bus.rd_valid), 0);
    checkOutput("rst_rl", int'(bus.rd_last), 0);
    checkOutput("rst_ovr", int'(bus.overrun), 0);
    checkOutput("rst_wb", int'(bus.wr_bank), 0);
`ifdef FRAME_BUF_OVR_CNT_EN
    checkOutput("rst_cnt", int'(bus.overrun_cnt), 0);
`endif

    // Idle reads, a partial frame, then a reset that discards it
    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v].re, vecs[v].iv, int'(vecs[v].d), vecs[v].ren);
      checkOutput($sformatf("vec%0d_fr", v), int'(bus.frame_ready), int'(vecs[v].exp_fr));
      checkOutput($sformatf("vec%0d_rv", v), int'(bus.rd_valid), int'(vecs[v].exp_rv));
      checkOutput($sformatf("vec%0d_ovr", v), int'(bus.overrun), int'(vecs[v].exp_ovr));
      checkOutput($sformatf("vec%0d_wb", v), int'(bus.wr_bank), int'(vecs[v].exp_wb));
      checkOutput($sformatf("vec%0d_data", v), int'(bus.rd_data), 0);
    end

    // First frame 0..63
    for (int i = 0; i < N; i++) begin
      applyStimulus(1'b0, 1'b1, i, 1'b0);
      if (i < N - 1) checkOutput("fill1_fr", int'(bus.frame_ready), 0);
    end
    checkOutput("fill1_fr_done", int'(bus.frame_ready), 1);
    checkOutput("fill1_wb", int'(bus.wr_bank), 1);
    checkOutput("fill1_ovr", int'(bus.overrun), 0);

    readFrame("read1", 0);
    applyStimulus(1'b0, 1'b0, 0, 1'b0);
    checkOutput("read1_rv_after", int'(bus.rd_valid), 0);
    checkOutput("read1_hold", int'(bus.rd_data), 63);

    // rd_en with no frame held is ignored
    applyStimulus(1'b0, 1'b0, 0, 1'b1);
    applyStimulus(1'b0, 1'b0, 0, 1'b1);
    checkOutput("nofr_rv", int'(bus.rd_valid), 0);
    checkOutput("nofr_hold", int'(bus.rd_data), 63);

    // Overrun: A held and unread, B dropped
    writeFrame(0);
    checkOutput("ovrA_fr", int'(bus.frame_ready), 1);
    checkOutput("ovrA_wb", int'(bus.wr_bank), 0);
    for (int i = 0; i < N; i++) begin
      applyStimulus(1'b0, 1'b1, 100 + i, 1'b0);
      checkOutput("ovrB_pulse", int'(bus.overrun), (i == N - 1) ? 1 : 0);
    end
    checkOutput("ovrB_fr", int'(bus.frame_ready), 1);
    checkOutput("ovrB_wb", int'(bus.wr_bank), 0);
    applyStimulus(1'b0, 1'b0, 0, 1'b0);
    checkOutput("ovr_one_cycle", int'(bus.overrun), 0);
`ifdef FRAME_BUF_OVR_CNT_EN
    checkOutput("ovr_cnt", int'(bus.overrun_cnt), 1);
`endif
    readFrame("readA", 0);

    // Aligned final read and final write: swap without overrun
    writeFrame(200);
    checkOutput("algn_fr", int'(bus.frame_ready), 1);
    checkOutput("algn_wb", int'(bus.wr_bank), 1);
    for (int k = 0; k < N; k++) begin
      applyStimulus(1'b0, 1'b1, 300 + k, 1'b1);
      checkOutput("algn_data", int'(bus.rd_data), 200 + k);
      checkOutput("algn_last", int'(bus.rd_last), (k == N - 1) ? 1 : 0);
      checkOutput("algn_ovr", int'(bus.overrun), 0);
    end
    checkOutput("algn_fr_kept", int'(bus.frame_ready), 1);
    checkOutput("algn_wb_swap", int'(bus.wr_bank), 0);
    readFrame("readB2", 300);

    // Reset mid-frame with a frame held
    writeFrame(400);
    checkOutput("mrst_held", int'(bus.frame_ready), 1);
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b0, 1'b1, 600 + i, 1'b0);
    end
    applyStimulus(1'b1, 1'b1, 999, 1'b1);
    checkOutput("mrst_fr", int'(bus.frame_ready), 0);
    checkOutput("mrst_wb", int'(bus.wr_bank), 0);
    checkOutput("mrst_rv", int'(bus.rd_valid), 0);
    checkOutput("mrst_rl", int'(bus.rd_last), 0);
    checkOutput("mrst_ovr", int'(bus.overrun), 0);
    checkOutput("mrst_data", int'(bus.rd_data), 0);
    writeFrame(500);
    checkOutput("post_fr", int'(bus.frame_ready), 1);
    checkOutput("post_wb", int'(bus.wr_bank), 1);
    checkOutput("post_ovr", int'(bus.overrun), 0);
    readFrame("post", 500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
